// File: rtl/corr_pkg.sv
// Shared definitions for the correlation frame packer and its host-side decoder.
// Holds the FSM state encoding, the default sync header bytes and the
// frame-geometry helper functions.
package corr_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        SEQ  = 3'd3,
        DATA = 3'd4,
        CSUM = 3'd5
    } state_t;

    localparam logic [7:0] SYNC0_BYTE = 8'hA5;
    localparam logic [7:0] SYNC1_BYTE = 8'h5A;

    // Whole bytes needed to carry one count of width res.
    function automatic int unsigned bytes_per_count(input int unsigned res);
        return (res + 32'd7) / 32'd8;
    endfunction

    // Total bytes in one frame: two sync bytes, SEQ, payload, CSUM.
    function automatic int unsigned frame_length(input int unsigned ncorr,
                                                 input int unsigned res);
        return 32'd4 + ncorr * bytes_per_count(res);
    endfunction

endpackage

// File: rtl/corr_frame_packer_if.sv
// Byte-stream valid/ready link from the frame packer to the UART transmitter.
//   tx_data  : byte offered to the transmitter
//   tx_valid : tx_data is valid
//   tx_ready : transmitter accepts the byte this cycle
interface corr_frame_packer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/corr_snapshot_mux.sv
// Snapshot register for the correlation count vector plus the payload byte
// selector. Byte i of the payload is byte (BPC-1 - i mod BPC) of count i/BPC,
// i.e. counts go out in index order, each MSB byte first.
//   clki, rst_n : clock, synchronous active-low reset
//   load        : capture counts into the snapshot
//   counts      : flat count vector, count k at [k*RESOLUTION +: RESOLUTION]
//   byte_idx    : payload byte index to select
//   byte_c      : selected payload byte (combinational from the snapshot)
module corr_snapshot_mux
    import corr_pkg::*;
#(
    parameter int unsigned RESOLUTION      = 16,
    parameter int unsigned NUM_CORRELATORS = 66,
    parameter int unsigned IDX_W           = 8
) (
    input  logic                                  clki,
    input  logic                                  rst_n,
    input  logic                                  load,
    input  logic [NUM_CORRELATORS*RESOLUTION-1:0] counts,
    input  logic [IDX_W-1:0]                      byte_idx,
    output logic [7:0]                            byte_c
);

    localparam int unsigned BPC       = bytes_per_count(RESOLUTION);
    localparam int unsigned CW        = BPC * 8;
    localparam int unsigned NUM_BYTES = NUM_CORRELATORS * BPC;

    logic [NUM_CORRELATORS*RESOLUTION-1:0] snap_q, snap_d;
    logic [7:0]                            stream [NUM_BYTES];
    logic [CW-1:0]                         word;

    // Snapshot capture.
    always_comb begin
        snap_d = snap_q;
        if (load) begin
            snap_d = counts;
        end
    end

    always_ff @(posedge clki) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    // Lay the snapshot out as the payload byte stream (zero-extended counts).
    always_comb begin
        word = '0;
        for (int k = 0; k < int'(NUM_CORRELATORS); k++) begin
            word = CW'(snap_q[k*RESOLUTION +: RESOLUTION]);
            for (int b = 0; b < int'(BPC); b++) begin
                stream[k*BPC + b] = word[(BPC-1-b)*8 +: 8];
            end
        end
    end

    // Indices past the payload read as zero.
    always_comb begin
        byte_c = '0;
        if (32'(byte_idx) < NUM_BYTES) begin
            byte_c = stream[byte_idx];
        end
    end

endmodule

// File: rtl/corr_frame_packer.sv
// Frames snapshots of the correlation count vector into a byte stream:
// SYNC0, SYNC1, SEQ, payload (counts MSB byte first), CSUM = XOR(SEQ, payload).
// Strobes arriving while a frame is in flight are dropped and counted.
//   clki, rst_n           : clock, synchronous active-low reset
//   integration_clk_pulse : counts are final, snapshot now
//   counts                : flat count vector
//   tx                    : byte stream to the UART transmitter (master side)
//   busy                  : frame in progress
//   overrun               : one-cycle pulse per dropped strobe
//   drop_count            : saturating dropped-strobe counter
module corr_frame_packer
    import corr_pkg::*;
#(
    parameter int unsigned RESOLUTION      = 16,
    parameter int unsigned NUM_INPUTS      = 12,
    parameter int unsigned NUM_CORRELATORS = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
    parameter logic [7:0]  SYNC0           = SYNC0_BYTE,
    parameter logic [7:0]  SYNC1           = SYNC1_BYTE
) (
    input  logic                                  clki,
    input  logic                                  rst_n,
    input  logic                                  integration_clk_pulse,
    input  logic [NUM_CORRELATORS*RESOLUTION-1:0] counts,
    corr_frame_packer_if.master                   tx,
    output logic                                  busy,
    output logic                                  overrun,
    output logic [7:0]                            drop_count
);

    localparam int unsigned BPC       = bytes_per_count(RESOLUTION);
    localparam int unsigned NUM_BYTES = NUM_CORRELATORS * BPC;
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t             state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         drop_q, drop_d;
    logic [7:0]         seq_q, seq_d;
    logic [7:0]         csum_q, csum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   sel_idx_c;
    logic [7:0]         mux_byte_c;
    logic               snap_load_c;
    logic               accept_c;

    assign accept_c = tx_valid_q && tx.tx_ready;

    // Byte to load next: payload byte 0 when leaving SEQ, else the successor.
    always_comb begin
        sel_idx_c = idx_q + IDX_W'(1);
        if (state_q == SEQ) begin
            sel_idx_c = '0;
        end
    end

    corr_snapshot_mux #(
        .RESOLUTION      (RESOLUTION),
        .NUM_CORRELATORS (NUM_CORRELATORS),
        .IDX_W           (IDX_W)
    ) u_snapshot_mux (
        .clki     (clki),
        .rst_n    (rst_n),
        .load     (snap_load_c),
        .counts   (counts),
        .byte_idx (sel_idx_c),
        .byte_c   (mux_byte_c)
    );

    // Frame sequencing; the next byte is loaded into tx_data on each acceptance.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        overrun_d   = 1'b0;
        drop_d      = drop_q;
        seq_d       = seq_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        snap_load_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (integration_clk_pulse) begin
                    state_d     = HDR0;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = SYNC0;
                    csum_d      = '0;
                    idx_d       = '0;
                    snap_load_c = 1'b1;
                end
            end
            HDR0: begin
                if (accept_c) begin
                    state_d   = HDR1;
                    tx_data_d = SYNC1;
                end
            end
            HDR1: begin
                if (accept_c) begin
                    state_d   = SEQ;
                    tx_data_d = seq_q;
                end
            end
            SEQ: begin
                if (accept_c) begin
                    state_d   = DATA;
                    csum_d    = csum_q ^ tx_data_q;
                    idx_d     = '0;
                    tx_data_d = mux_byte_c;
                end
            end
            DATA: begin
                if (accept_c) begin
                    csum_d = csum_q ^ tx_data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d   = CSUM;
                        tx_data_d = csum_q ^ tx_data_q;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        tx_data_d = mux_byte_c;
                    end
                end
            end
            CSUM: begin
                if (accept_c) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = '0;
                    seq_d      = seq_q + 8'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = '0;
            end
        endcase

        // Any strobe outside IDLE is dropped, including the final CSUM cycle.
        if (integration_clk_pulse && (state_q != IDLE)) begin
            overrun_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clki) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            drop_q     <= '0;
            seq_q      <= '0;
            csum_q     <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            drop_q     <= drop_d;
            seq_q      <= seq_d;
            csum_q     <= csum_d;
            idx_q      <= idx_d;
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_corr_frame_packer.sv
// Bench for corr_frame_packer at NUM_INPUTS=3, RESOLUTION=16 (3 counts, 10-byte
// frames). A queue-based frame model predicts every output each cycle; literal
// frames pin the model on the documented cases.
module tb_corr_frame_packer;

    localparam int R   = 16;
    localparam int NC  = 3;
    localparam int BPC = (R + 7) / 8;

    logic            clki;
    logic            rst_n;
    logic            strobe;
    logic [NC*R-1:0] counts;
    logic            busy;
    logic            overrun;
    logic [7:0]      drop_count;

    corr_frame_packer_if tx_if ();

    corr_frame_packer #(
        .RESOLUTION      (R),
        .NUM_INPUTS      (3),
        .NUM_CORRELATORS (NC),
        .SYNC0           (8'hA5),
        .SYNC1           (8'h5A)
    ) dut (
        .clki                  (clki),
        .rst_n                 (rst_n),
        .integration_clk_pulse (strobe),
        .counts                (counts),
        .tx                    (tx_if),
        .busy                  (busy),
        .overrun               (overrun),
        .drop_count            (drop_count)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    int tests    = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ovr   = 1'b0;
    logic [7:0] m_drop  = 8'h00;
    logic [7:0] m_seq   = 8'h00;

    function automatic void build_frame(input logic [NC*R-1:0] c, input logic [7:0] s);
        logic [7:0] cs;
        logic [7:0] bt;
        int unsigned v;
        mq.push_back(8'hA5);
        mq.push_back(8'h5A);
        mq.push_back(s);
        cs = s;
        for (int k = 0; k < NC; k++) begin
            v = 32'((c >> (k * R)) & 48'hFFFF);
            for (int b = BPC - 1; b >= 0; b--) begin
                bt = 8'((v >> (b * 8)) & 32'hFF);
                mq.push_back(bt);
                cs = cs ^ bt;
            end
        end
        mq.push_back(cs);
    endfunction

    always @(posedge clki) begin
        bit was_busy;
        if (!rst_n) begin
            mq.delete();
            m_ovr  = 1'b0;
            m_drop = 8'h00;
            m_seq  = 8'h00;
        end else begin
            was_busy = (mq.size() != 0);
            m_ovr    = 1'b0;
            if (m_valid && tx_if.tx_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_seq = m_seq + 8'd1;
            end
            if (strobe) begin
                if (!was_busy) build_frame(counts, m_seq);
                else begin
                    m_ovr = 1'b1;
                    if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                end
            end
        end
        m_valid = (mq.size() != 0);
        m_data  = m_valid ? mq[0] : 8'h00;
    end

    // ---------------- per-cycle compare + transfer log ----------------
    bit         check_en = 1'b0;
    logic [7:0] log_q[$];

    always @(negedge clki) begin
        if (check_en) begin
            chk("tx_valid",   32'(tx_if.tx_valid), 32'(m_valid));
            chk("tx_data",    32'(tx_if.tx_data),  32'(m_data));
            chk("busy",       32'(busy),           32'(m_valid));
            chk("overrun",    32'(overrun),        32'(m_ovr));
            chk("drop_count", 32'(drop_count),     32'(m_drop));
            if (tx_if.tx_valid && tx_if.tx_ready) log_q.push_back(tx_if.tx_data);
        end
    end

    // ---------------- stimulus ----------------
    int rdy_mode  = 0;   // 0 always ready, 1 pattern 1-0-0-1, 2 random, 3 never
    bit rand_cnts = 1'b0;
    int cyc       = 0;

    localparam logic [NC*R-1:0] LIT_COUNTS = {16'h0003, 16'h0102, 16'hABCD};

    task automatic step();
        @(posedge clki);
        #2;
        cyc++;
        case (rdy_mode)
            0: tx_if.tx_ready = 1'b1;
            1: tx_if.tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2: tx_if.tx_ready = ($urandom_range(3) != 0);
            default: tx_if.tx_ready = 1'b0;
        endcase
        if (rand_cnts) counts = NC*R'({$urandom(), $urandom()});
    endtask

    task automatic start_frame();
        strobe = 1'b1;
        step();
        strobe = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic chk_frame(input string nm, input int base, input logic [79:0] e);
        chk({nm, "_len"}, 32'(log_q.size() >= base + 10), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (base + i < log_q.size()) chk(nm, 32'(log_q[base + i]), 32'(e[(9 - i) * 8 +: 8]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        strobe         = 1'b0;
        counts         = LIT_COUNTS;
        tx_if.tx_ready = 1'b1;
        step();
        step();
        step();
        rst_n    = 1'b1;
        check_en = 1'b1;
        chk("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("rst_tx_data",  32'(tx_if.tx_data),  32'd0);
        chk("rst_busy",     32'(busy),           32'd0);
        chk("rst_drop",     32'(drop_count),     32'd0);

        // Basic frame, always ready.
        log_q.delete();
        start_frame();
        chk("first_byte_sync0", 32'(tx_if.tx_data), 32'hA5);
        wait_idle(40);
        chk_frame("frame0", 0, 80'hA55A00ABCD0102000366);
        chk("frame0_count", 32'(log_q.size()), 32'd10);

        // Back-pressure pattern, second frame carries SEQ=01.
        log_q.delete();
        rdy_mode = 1;
        start_frame();
        wait_idle(80);
        chk_frame("frame1_stall", 0, 80'hA55A01ABCD0102000367);
        chk("frame1_count", 32'(log_q.size()), 32'd10);

        // Strobe mid-DATA is dropped.
        rdy_mode = 0;
        start_frame();
        step();
        step();
        step();
        step();
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        chk("drop_overrun", 32'(overrun),    32'd1);
        chk("drop_count1",  32'(drop_count), 32'd1);
        step();
        chk("drop_overrun_clr", 32'(overrun), 32'd0);
        wait_idle(40);

        // 300 strobes against a stalled frame saturate the drop counter.
        rdy_mode = 3;
        start_frame();
        strobe = 1'b1;
        for (int i = 0; i < 300; i++) step();
        strobe = 1'b0;
        chk("drop_sat", 32'(drop_count), 32'd255);
        rdy_mode = 0;
        step();
        wait_idle(40);

        // Random strobes, random back-pressure, counts changing every cycle.
        rdy_mode  = 2;
        rand_cnts = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            strobe = ($urandom_range(9) == 0);
            step();
        end
        strobe    = 1'b0;
        rand_cnts = 1'b0;
        rdy_mode  = 0;
        step();
        wait_idle(60);

        // Reset during DATA abandons the frame.
        counts = LIT_COUNTS;
        start_frame();
        step();
        step();
        step();
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        do_reset();
        chk("mid_rst_valid",   32'(tx_if.tx_valid), 32'd0);
        chk("mid_rst_busy",    32'(busy),           32'd0);
        chk("mid_rst_drop",    32'(drop_count),     32'd0);
        chk("mid_rst_overrun", 32'(overrun),        32'd0);
        log_q.delete();
        start_frame();
        wait_idle(40);
        chk_frame("after_rst", 0, 80'hA55A00ABCD0102000366);

        // SEQ wraps after 256 frames.
        do_reset();
        log_q.delete();
        for (int f = 0; f < 257; f++) begin
            start_frame();
            wait_idle(40);
        end
        chk_frame("seq_ff",   2550, 80'hA55AFFABCD0102000399);
        chk_frame("seq_wrap", 2560, 80'hA55A00ABCD0102000366);

        step();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/corr_frame_packer.md
# corr_frame_packer

Downstream stage of the correlator array: on each integration strobe it snapshots the flat vector of pairwise correlation counts and serialises it as a framed byte stream to the UART transmitter. Each frame carries a sync header, a sequence number, every count MSB-first, and an XOR checksum. The block sits between the correlator accumulators and the UART TX byte interface. While a frame is in flight, further snapshots are dropped and counted.

## Interface
Parameters:
- RESOLUTION, 16, bit width of each correlation count
- NUM_INPUTS, 12, number of pulse inputs
- NUM_CORRELATORS, NUM_INPUTS*(NUM_INPUTS-1)/2, number of counts per frame
- SYNC0, 8'hA5, first header byte
- SYNC1, 8'h5A, second header byte

Ports:
- clki  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- integration_clk_pulse  in  1  one-cycle strobe: counts are final, latch now
- counts  in  NUM_CORRELATORS*RESOLUTION  count k at bits [k*RESOLUTION +: RESOLUTION]
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts the byte this cycle
- busy  out  1  frame in progress (state != IDLE)
- overrun  out  1  one-cycle pulse when a strobe is dropped
- drop_count  out  8  saturating count of dropped strobes

## Operation
- BPC = (RESOLUTION+7)/8 bytes per count. Each count is zero-extended to BPC*8 bits and sent MSB byte first. Counts are sent in order k = 0 .. NUM_CORRELATORS-1.
- Frame layout: SYNC0, SYNC1, SEQ, data bytes, CSUM. Frame length = 4 + NUM_CORRELATORS*BPC (136 bytes at the defaults).
- SEQ is an 8-bit frame counter. It is 0 after reset and increments by 1 (wrapping 255→0) when the CSUM byte is accepted.
- CSUM = XOR of SEQ and all data bytes. The header bytes are excluded.
- States and transitions:
  - IDLE → HDR0 on strobe
  - HDR0 → HDR1 → SEQ → DATA, each on an accepted byte
  - DATA stays in DATA until the last data byte is accepted, then → CSUM
  - CSUM → IDLE on acceptance
- Strobe in IDLE: counts are copied into a snapshot register. Later changes on counts do not affect the frame.
- Strobe in any state other than IDLE, including the cycle the CSUM byte is accepted:
  - strobe is ignored
  - overrun pulses for one cycle
  - drop_count increments, saturating at 255
- Byte handshake: a byte transfers on a cycle with tx_valid && tx_ready.
  - While tx_valid is high and tx_ready is low, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer.
- Reset, including mid-frame:
  - state → IDLE
  - tx_valid=0, tx_data=0, busy=0, overrun=0
  - drop_count=0, SEQ=0
  - snapshot and checksum registers cleared
  - a partial frame is abandoned and not resumed

## Timing
- Strobe accepted at cycle N: tx_valid=1 with tx_data=SYNC0 from cycle N+1.
- With tx_ready held high, one byte transfers per cycle. The CSUM byte is presented at cycle N+frame_length. busy falls at cycle N+frame_length+1.
- The next strobe is accepted no earlier than the cycle busy reads 0.
- overrun asserts in the cycle after the dropped strobe.
- drop_count updates in that same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Byte index counter width is clog2(NUM_CORRELATORS*BPC). Checksum is an 8-bit running XOR, updated on each accepted SEQ or data byte.

## Structure
- Shared package corr_pkg holds:
  - state enum (IDLE, HDR0, HDR1, SEQ, DATA, CSUM)
  - SYNC0/SYNC1 constants
  - BPC and frame-length functions, which the host-side decoder spec also uses
- One sub-module is natural: corr_snapshot_mux. It holds the snapshot register and selects the byte at byte index i:
  - count = i / BPC
  - byte = BPC-1 - (i mod BPC)
- FSM, SEQ counter, checksum and drop counter live in the top.

## Test plan
- NUM_INPUTS=3, RESOLUTION=16, counts={16'h0003,16'h0102,16'hABCD} (k2,k1,k0), tx_ready=1, one strobe → bytes A5 5A 00 AB CD 01 02 00 03, then CSUM=AB^CD^01^02^00^03=66; busy low after 10 transfers.
- Same config, tx_ready toggling 1-0-0-1 pattern → identical byte sequence; tx_data is stable while stalled; no byte is duplicated or skipped.
- Two full frames back-to-back → second frame SEQ=01; 256 frames → SEQ wraps to 00.
- Strobe while busy mid-DATA → overrun pulse one cycle later, drop_count=1, current frame bytes unchanged; 300 dropped strobes → drop_count=255.
- Change counts during frame → transmitted bytes equal the snapshot taken at the strobe.
- Assert rst_n=0 for one cycle during DATA → next cycle tx_valid=0, busy=0, drop_count=0; next strobe produces a full frame with SEQ=00.
